// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared serdes types, defaults and the parity helper
//   deser_state_t : receiver FSM states (PAR only reachable with PARITY_CHECK_EN)
//   DEFAULT_WIDTH : default data bits per frame
//   even_parity() : parity bit that makes the word plus that bit have even weight;
//                   narrower words are zero-extended, which leaves the result unchanged
package serdes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } deser_state_t;

  localparam int DEFAULT_WIDTH = 8;

  function automatic logic even_parity(input logic [63:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - LSB-first serial-to-parallel receiver with one-word output buffer
//   Optional feature macro: PARITY_CHECK_EN (adds an even-parity bit after the data bits)
//   clk       in   rising-edge clock
//   rst       in   synchronous reset, active-low
//   sdata     in   serial data, LSB first
//   bit_en    in   sdata carries a valid bit this cycle
//   sync      in   with bit_en: this bit is bit 0 of a new frame
//   out_data  out  assembled word
//   out_valid out  out_data holds an unconsumed word
//   out_ready in   consumer accepts out_data when out_valid && out_ready
//   overrun   out  one-cycle pulse when a completed word is dropped
//   par_err   out  parity result belonging to out_data (0 without PARITY_CHECK_EN)
module sipo_deser
  import serdes_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sdata,
  input  logic             bit_en,
  input  logic             sync,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             par_err
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST_DATA_CNT = CW'(WIDTH - 1);

  deser_state_t     state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word;
  logic             done;

`ifdef PARITY_CHECK_EN
  logic             perr_q, perr_d;
  logic             word_perr;
`else
  // Without the parity bit the LSB shifts straight out into the completed word.
  logic             unused_shift_lsb;
  assign unused_shift_lsb = shift_q[0];
`endif

  assign shifted = {sdata, shift_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    word      = shifted;
    done      = 1'b0;
`ifdef PARITY_CHECK_EN
    perr_d    = perr_q;
    word_perr = 1'b0;
`endif

    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    if (bit_en) begin
      if (sync) begin
        // Start (or restart) a frame: older partial bits are discarded.
        state_d   = SHIFT;
        bit_cnt_d = CW'(1);
        shift_d   = {sdata, {(WIDTH-1){1'b0}}};
      end else begin
        case (state_q)
          IDLE: begin
          end
          SHIFT: begin
            shift_d = shifted;
            if (bit_cnt_q == LAST_DATA_CNT) begin
`ifdef PARITY_CHECK_EN
              state_d   = PAR;
              bit_cnt_d = bit_cnt_q + 1'b1;
`else
              state_d   = IDLE;
              bit_cnt_d = '0;
              done      = 1'b1;
              word      = shifted;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
`ifdef PARITY_CHECK_EN
          PAR: begin
            // Parity bit is not shifted in; shift_q already holds the data.
            state_d   = IDLE;
            bit_cnt_d = '0;
            done      = 1'b1;
            word      = shift_q;
            word_perr = even_parity(64'(shift_q)) ^ sdata;
          end
`endif
          default: begin
            state_d   = IDLE;
            bit_cnt_d = '0;
          end
        endcase
      end
    end

    if (done) begin
      if (valid_q && !out_ready) begin
        // Held word has priority; the new one is lost.
        overrun_d = 1'b1;
      end else begin
        data_d  = word;
        valid_d = 1'b1;
`ifdef PARITY_CHECK_EN
        perr_d  = word_perr;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef PARITY_CHECK_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
`ifdef PARITY_CHECK_EN
      perr_q    <= perr_d;
`endif
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;
`ifdef PARITY_CHECK_EN
  assign par_err   = perr_q;
`else
  assign par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// tb/tb_sipo_deser.sv - directed self-checking bench for sipo_deser
module tb_sipo_deser;

`ifdef PARITY_CHECK_EN
  localparam int FB = 9;
`else
  localparam int FB = 8;
`endif

  logic       clk;
  logic       rst;
  logic       sdata;
  logic       bit_en;
  logic       sync;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       overrun;
  logic       par_err;

  int checks;
  int errors;

  sipo_deser #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .sdata     (sdata),
    .bit_en    (bit_en),
    .sync      (sync),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .par_err   (par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    bit_en = 1'b0;
    sync   = 1'b0;
    sdata  = 1'b0;
  endtask

  // Drive frame bits first..last, one per cycle unless gapped; sync on bit 0.
  task automatic send_bits(input logic [8:0] fr, input int first, input int last, input bit gapped);
    for (int i = first; i <= last; i++) begin
      if (gapped) begin
        repeat ($urandom_range(1, 4)) begin
          @(negedge clk);
          bit_en = 1'b0;
          sdata  = 1'($urandom);
          sync   = 1'($urandom);
        end
      end
      @(negedge clk);
      bit_en = 1'b1;
      sdata  = fr[i];
      sync   = (i == 0);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    bit_en    = 1'b0;
    sync      = 1'b0;
    sdata     = 1'b0;
    out_ready = 1'b0;

    // Reset with random inputs
    repeat (2) begin
      @(negedge clk);
      bit_en    = 1'($urandom);
      sync      = 1'($urandom);
      sdata     = 1'($urandom);
      out_ready = 1'($urandom);
    end
    next_cycle();
    check("rst_valid",   32'(out_valid), 32'd0);
    check("rst_data",    32'(out_data),  32'h00);
    check("rst_overrun", 32'(overrun),   32'd0);
    check("rst_par_err", 32'(par_err),   32'd0);
    rst       = 1'b1;
    out_ready = 1'b1;
    next_cycle();

    // Basic frame, back-to-back bits, consumer ready
    send_bits({1'b0, 8'hA5}, 0, FB-1, 1'b0);
    next_cycle();
    check("basic_valid",   32'(out_valid), 32'd1);
    check("basic_data",    32'(out_data),  32'hA5);
    check("basic_par_err", 32'(par_err),   32'd0);
    next_cycle();
    check("basic_drop",    32'(out_valid), 32'd0);

    // Gapped bits, consumer stalled so an early word would be held
    out_ready = 1'b0;
    send_bits({1'b0, 8'h3C}, 0, FB-2, 1'b1);
    next_cycle();
    check("gap_no_early", 32'(out_valid), 32'd0);
    send_bits({1'b0, 8'h3C}, FB-1, FB-1, 1'b1);
    next_cycle();
    check("gap_valid", 32'(out_valid), 32'd1);
    check("gap_data",  32'(out_data),  32'h3C);
    out_ready = 1'b1;
    next_cycle();
    check("gap_drop",  32'(out_valid), 32'd0);

    // Backpressure and overrun
    out_ready = 1'b0;
    send_bits({1'b0, 8'h3C}, 0, FB-1, 1'b0);
    next_cycle();
    check("bp_valid1",   32'(out_valid), 32'd1);
    check("bp_data1",    32'(out_data),  32'h3C);
    check("bp_ovr_pre",  32'(overrun),   32'd0);
    send_bits({1'b0, 8'h81}, 0, FB-1, 1'b0);
    next_cycle();
    check("bp_ovr_hit",  32'(overrun),   32'd1);
    check("bp_data_hold",32'(out_data),  32'h3C);
    check("bp_valid2",   32'(out_valid), 32'd1);
    next_cycle();
    check("bp_ovr_post", 32'(overrun),   32'd0);
    check("bp_data_keep",32'(out_data),  32'h3C);
    out_ready = 1'b1;
    next_cycle();
    check("bp_accept",   32'(out_valid), 32'd0);

    // Resync after 3 bits, then a full frame
    out_ready = 1'b0;
    send_bits({1'b0, 8'hFF}, 0, 2, 1'b0);
    send_bits({1'b0, 8'h5A}, 0, FB-2, 1'b0);
    next_cycle();
    check("resync_no_early", 32'(out_valid), 32'd0);
    send_bits({1'b0, 8'h5A}, FB-1, FB-1, 1'b0);
    next_cycle();
    check("resync_valid", 32'(out_valid), 32'd1);
    check("resync_data",  32'(out_data),  32'h5A);
    out_ready = 1'b1;
    next_cycle();
    check("resync_drop",  32'(out_valid), 32'd0);

    // Reset mid-frame discards the partial frame and the held word
    out_ready = 1'b0;
    send_bits({1'b0, 8'h3C}, 0, FB-1, 1'b0);
    next_cycle();
    check("mid_held", 32'(out_valid), 32'd1);
    send_bits({1'b0, 8'hC3}, 0, 3, 1'b0);
    next_cycle();
    rst = 1'b0;
    next_cycle();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data",  32'(out_data),  32'h00);
    rst = 1'b1;
    send_bits({1'b0, 8'hC3}, 4, FB-1, 1'b0);
    next_cycle();
    next_cycle();
    check("mid_no_word",   32'(out_valid), 32'd0);
    check("mid_overrun",   32'(overrun),   32'd0);

`ifdef PARITY_CHECK_EN
    // Parity: good then bad parity bit on the same data
    send_bits({1'b0, 8'hA5}, 0, FB-1, 1'b0);
    next_cycle();
    check("par_good_valid", 32'(out_valid), 32'd1);
    check("par_good_data",  32'(out_data),  32'hA5);
    check("par_good_err",   32'(par_err),   32'd0);
    out_ready = 1'b1;
    next_cycle();
    out_ready = 1'b0;
    send_bits({1'b1, 8'hA5}, 0, FB-1, 1'b0);
    next_cycle();
    check("par_bad_valid",  32'(out_valid), 32'd1);
    check("par_bad_data",   32'(out_data),  32'hA5);
    check("par_bad_err",    32'(par_err),   32'd1);
    out_ready = 1'b1;
    next_cycle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
